instruction_prefetch: RTL

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

---
 rtl/instruction_prefetch_pkg.sv | 21 ++
 rtl/instruction_prefetch_fifo.sv | 56 +++++
 rtl/instruction_prefetch.sv | 112 +++++++++++
 3 files changed

// File: rtl/instruction_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package instruction_prefetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  localparam logic [ADDR_W-1:0] PC_INCR          = 32'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  function automatic logic [ADDR_W-1:0] alignPC(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_prefetch_fifo.sv
// Prefetch queue: DEPTH entries of {PC, instruction}, head exposed combinationally from storage.
module prefetch_fifo
  import instruction_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        pushPC,
  input  logic [INSTR_W-1:0]       pushInstr,
  output logic                     headValid,
  output logic [ADDR_W-1:0]        headPC,
  output logic [INSTR_W-1:0]       headInstr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wrPtr;
  logic [PW-1:0]      rdPtr;
  logic               doPush;
  logic               doPop;

  assign doPush = push && (count != CW'(DEPTH));
  assign doPop  = pop && (count != '0);

  // Storage is reset so the head reads as zero until the first push.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= {pushPC, pushInstr};
        wrPtr      <= wrPtr + PW'(1);
      end
      if (doPop) rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  assign headValid            = (count != '0);
  assign {headPC, headInstr}  = mem[rdPtr];

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetch: keeps a small queue of sequential instructions ahead of the
// Controller, one cache request in flight at a time, flushed and retargeted on redirect.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no request outstanding; issue one when the queue has room
//   REQ     | request to memAddr outstanding, memReq high
//   DISCARD | request outstanding but redirected away; its data is dropped
module instruction_prefetch
  import instruction_prefetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clock,
  input  logic                   resetN,
  output logic                   memReq,
  output logic [ADDR_W-1:0]      memAddr,
  input  logic                   memAck,
  input  logic [INSTR_W-1:0]     memData,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirectPC,
  output logic                   instrValid,
  output logic [INSTR_W-1:0]     instruction,
  output logic [ADDR_W-1:0]      instrPC,
  input  logic                   instrReady,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depthCheck
    $error("instruction_prefetch: DEPTH must be a power of two in 2..16");
  end

  fetchState_t       state;
  logic [ADDR_W-1:0] fetchPC;
  logic              started;
  logic              push;
  logic              pop;
  logic [CW:0]       occAfter;
  logic              roomAfter;

  assign push = (state == REQ) && memAck && !redirect;
  assign pop  = instrValid && instrReady && !redirect;

  // Occupancy after this cycle's push and pop, widened so DEPTH itself fits.
  assign occAfter  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
  assign roomAfter = occAfter < (CW+1)'(DEPTH);

  // started delays the first request by one idle cycle after reset release.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      fetchPC <= RESET_PC;
      memReq  <= 1'b0;
      memAddr <= RESET_PC;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: begin
          if (redirect) begin
            fetchPC <= alignPC(redirectPC);
          end else if (started && (count < CW'(DEPTH))) begin
            state   <= REQ;
            memReq  <= 1'b1;
            memAddr <= fetchPC;
          end
        end
        REQ: begin
          if (redirect) begin
            fetchPC <= alignPC(redirectPC);
            memReq  <= 1'b0;
            state   <= memAck ? IDLE : DISCARD;
          end else if (memAck) begin
            fetchPC <= fetchPC + PC_INCR;
            if (roomAfter) begin
              memAddr <= fetchPC + PC_INCR;
            end else begin
              state  <= IDLE;
              memReq <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (redirect) fetchPC <= alignPC(redirectPC);
          if (memAck) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          memReq <= 1'b0;
        end
      endcase
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .resetN    (resetN),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .pushPC    (fetchPC),
    .pushInstr (memData),
    .headValid (instrValid),
    .headPC    (instrPC),
    .headInstr (instruction),
    .count     (count)
  );

endmodule
